// File: rtl/i_fetch_pkg.sv
// Shared constants for the DLX fetch/decode stages: nop encoding, opcode
// constants and the fetch FSM state encoding.
package i_fetch_pkg;

  localparam int          DATA_W         = 32;
  localparam logic [31:0] NOP_INSTR      = 32'h54000000;
  localparam logic [5:0]  OP_JAL         = 6'h03;
  localparam logic [2:0]  OP_LOAD_PREFIX = 3'b100;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

  // Instruction bit 0 is the MSB, so opcode bits [0:5] sit at [31:26] here.
  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic is_load(input logic [31:0] instr);
    return instr[31:29] == OP_LOAD_PREFIX;
  endfunction

endpackage

// File: rtl/i_fetch_if.sv
// Fetch-stage bundle: instruction-memory port, decode back-channel, stall and
// the IF/ID register outputs. master = fetch stage, slave = memory/decode side.
interface i_fetch_if;
  import i_fetch_pkg::*;

  logic              stall;
  logic              jump_or_branch;
  logic [DATA_W-1:0] target;
  logic              reg_lock_if;
  logic [DATA_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic [DATA_W-1:0] instruction;
  logic [DATA_W-1:0] pc_plus_four;
  logic              hold_active;

  modport master (
    input  stall, jump_or_branch, target, reg_lock_if, imem_data,
    output imem_addr, instruction, pc_plus_four, hold_active
  );

  modport slave (
    output stall, jump_or_branch, target, reg_lock_if, imem_data,
    input  imem_addr, instruction, pc_plus_four, hold_active
  );

endinterface

// File: rtl/adder_n.sv
// Generic N-bit ripple adder with carry-in; carry-out is dropped (modulo 2^N).
module adder_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum
);

  assign sum = a + b + {{(N-1){1'b0}}, cin};

endmodule

// File: rtl/i_fetch.sv
// DLX instruction-fetch stage: PC, IF/ID register, redirect/lock/stall handling.
// Define I_FETCH_DELAY_SLOT_EN to keep the delay-slot instruction on redirects.
module i_fetch
  import i_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter int          JAL_HOLD  = 2,
  parameter int          LOAD_HOLD = 1
) (
  input  logic     clk,
  input  logic     reset,
  i_fetch_if.master bus
);

  fetch_state_t      state;
  logic [DATA_W-1:0] pc_p0;
  logic [DATA_W-1:0] instr_p1;
  logic [DATA_W-1:0] pc4_p1;
  logic [DATA_W-1:0] pend_target;
  logic [DATA_W-1:0] pc_inc;
  logic [DATA_W-1:0] redir_pc;
  logic [DATA_W-1:0] slot_instr;
  logic [3:0]        hold_cnt;
  logic [3:0]        lock_len;
  logic              pend_valid;
  logic              hold_active;
  logic              redir;

  adder_n #(.N(DATA_W)) u_pc_inc (
    .a   (pc_p0),
    .b   (32'h4),
    .cin (1'b0),
    .sum (pc_inc)
  );

  // A fresh request from decode is newer than anything parked during a stall.
  assign redir    = bus.jump_or_branch | pend_valid;
  assign redir_pc = bus.jump_or_branch ? bus.target : pend_target;
  assign lock_len = (opcode_of(instr_p1) == OP_JAL) ? 4'(JAL_HOLD) : 4'(LOAD_HOLD);

`ifdef I_FETCH_DELAY_SLOT_EN
  assign slot_instr = bus.imem_data;
`else
  assign slot_instr = NOP_INSTR;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc_p0       <= RESET_PC;
      instr_p1    <= NOP_INSTR;
      pc4_p1      <= RESET_PC;
      hold_cnt    <= 4'd0;
      pend_valid  <= 1'b0;
      hold_active <= 1'b0;
    end else if (bus.stall) begin
      if (bus.jump_or_branch) begin
        pend_valid  <= 1'b1;
        pend_target <= bus.target;
      end
    end else begin
      if (redir) begin
        pc_p0      <= redir_pc;
        pend_valid <= 1'b0;
      end
      if (state == HOLD) begin
        hold_cnt <= hold_cnt - 4'd1;
        if (hold_cnt <= 4'd1) begin
          state       <= RUN;
          hold_active <= 1'b0;
        end
      end else if (bus.reg_lock_if) begin
        // IF/ID stays put on the request edge even for a zero-length hold.
        if (lock_len != 4'd0) begin
          hold_cnt    <= lock_len;
          state       <= HOLD;
          hold_active <= 1'b1;
        end
      end else if (redir) begin
        instr_p1 <= slot_instr;
        pc4_p1   <= pc_inc;
      end else begin
        instr_p1 <= bus.imem_data;
        pc4_p1   <= pc_inc;
        pc_p0    <= pc_inc;
      end
    end
  end

  // ---- stage boundary: PC (IF) -> IF/ID register outputs ----
  assign bus.imem_addr    = pc_p0;
  assign bus.instruction  = instr_p1;
  assign bus.pc_plus_four = pc4_p1;
  assign bus.hold_active  = hold_active;

endmodule

// File: doc/i_fetch.md
# i_fetch

Instruction-fetch stage of the five-stage DLX pipeline: owns the program counter, drives the combinational instruction-memory address, and loads the IF/ID pipeline register (`instruction`, `pc_plus_four`) consumed by `i_decode`. It services the decode stage's back-channel: branch/jump redirects (`jump_or_branch`, `target`) and multi-cycle lock requests (`reg_lock_if`). It also freezes under an external pipeline stall without losing a redirect.

## Interface
- `RESET_PC`, 32'h00000000, PC value loaded on reset.
- `NOP_INSTR`, 32'h54000000, DLX nop (opcode 6'h15) injected on squash and reset.
- `JAL_HOLD`, 2, freeze cycles after a lock request for a `jal` (opcode 6'h03) in IF/ID.
- `LOAD_HOLD`, 1, freeze cycles after a lock request for a load (opcode[0:2] == 3'b100) in IF/ID.
- `clk`  in  1  pipeline clock.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  external hold (multiplier lock); freezes PC and IF/ID.
- `jump_or_branch`  in  1  redirect request from decode, valid same cycle.
- `target`  in  32  redirect PC from decode.
- `reg_lock_if`  in  1  decode lock request, one-cycle pulse.
- `imem_addr`  out  32  instruction-memory address, equals current PC.
- `imem_data`  in  32  instruction word at `imem_addr`, combinational.
- `instruction`  out  32  IF/ID instruction, bits [0:31], bit 0 MSB.
- `pc_plus_four`  out  32  IF/ID PC+4 of `instruction`.
- `hold_active`  out  1  high while in HOLD state.

## Operation
- States: RUN, HOLD. Registers: `pc`, IF/ID pair, `hold_cnt` (4 bits), `pend_valid`, `pend_target`.
- Per-cycle priority: `reset` > `stall` > redirect > lock > sequential fetch.
- `reset`: `pc`=RESET_PC, `instruction`=NOP_INSTR, `pc_plus_four`=RESET_PC, state RUN, `hold_cnt`=0, `pend_valid`=0, `hold_active`=0.
- `stall`: `pc`, IF/ID, and `hold_cnt` unchanged. If `jump_or_branch`, set `pend_valid`=1 and `pend_target`=`target`. The latest request wins.
- Redirect (`jump_or_branch`, or `pend_valid` with no stall): `pc` <= `target` (or `pend_target`); clear `pend_valid`. The IF/ID load is governed by DELAY_SLOT_EN. A redirect in HOLD is applied to `pc`, and HOLD continues.
- Lock (`reg_lock_if` in RUN): hold length is JAL_HOLD if IF/ID opcode == 6'h03, else LOAD_HOLD. `hold_cnt` <= length, state HOLD. The IF/ID is not loaded this cycle. `pc` advances only if a redirect is also present. A zero-length hold stays in RUN.
- HOLD: `pc` and IF/ID frozen; `hold_cnt` decrements by 1 per non-stalled cycle. When it reaches 0, go to RUN.
- `reg_lock_if` in HOLD is ignored.
- RUN, sequential: IF/ID <= {`imem_data`, `pc`+4}; `pc` <= `pc`+4.
- Arithmetic: 32-bit unsigned, modulo 2^32. 32'hFFFFFFFC + 4 = 0. No alignment check.

## Timing
- `imem_addr` = `pc`, combinational; one instruction per unstalled RUN cycle.
- Fetch-to-IF/ID latency: 1 cycle.
- Redirect: `target` is at `imem_addr` the cycle after `jump_or_branch`. The target instruction is in IF/ID 2 cycles after the request.
- Lock with length N: IF/ID frozen for N+1 edges, counting the request edge; `hold_active` is high for N cycles.
- `reset` mid-HOLD or with a pending redirect: discards both, and the next edge applies the reset values.

## Configuration
- `I_FETCH_DELAY_SLOT_EN` defined: on a redirect cycle, IF/ID <= {`imem_data`, `pc`+4}. The sequential instruction executes as the delay slot.
- Undefined: on a redirect cycle, IF/ID <= {NOP_INSTR, `pc`+4}. The delay slot is squashed.
- This applies identically to pending redirects.

## Structure
- Shared package/header holds: NOP_INSTR, OP_JAL (6'h03), OP_LOAD_PREFIX (3'b100), and the RUN/HOLD state encodings. `i_decode` uses the same opcode constants.
- PC increment reuses the existing `adder_n`, with B=32'h4 and cin=0. No other sub-modules.

## Test plan
- Reset with RESET_PC=0, then 3 free cycles → `imem_addr` 0,4,8,12; `pc_plus_four` 4,8,12.
- `jump_or_branch`=1, `target`=32'h100 while `pc`=8 → next `imem_addr`=32'h100. IF/ID = {mem[8], 12} with DELAY_SLOT_EN, or {32'h54000000, 12} without.
- IF/ID holds a load (opcode 6'b100011) and `reg_lock_if` pulses → IF/ID frozen 2 edges, `hold_active` high 1 cycle, then fetch resumes at the unchanged `pc`.
- IF/ID holds `jal` with `jump_or_branch`+`reg_lock_if`, `target`=32'h40 → `pc`=32'h40; IF/ID frozen 3 edges; `hold_active` high 2 cycles.
- `stall`=1 for 3 cycles with `jump_or_branch` pulsed on cycle 2, `target`=32'h200 → no change during stall; the first unstalled edge sets `pc`=32'h200.
- `pc`=32'hFFFFFFFC, run 1 cycle → `imem_addr`=0 and `pc_plus_four`=0. Assert `reset` in HOLD → RUN, `pc`=RESET_PC, `instruction`=NOP.
